pipe_skid_stage: RTL and testbench

Parametrised pipeline stage register that replaces the fixed, stall-vector-driven inter-stage latches with a generic valid/ready stage. It carries an opaque payload of `DATA_W` bits between two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It supports an optional two-entry skid buffer so the upstream ready is fully registered, a flush that inserts a zeroed bubble, the global `rdy_in` freeze, and a saturating back-pressure counter for performance tuning.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_skid_stage.sv | 120 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and constants.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // EX/MEM bundle: rd(5) + alu(32) + flag(1) + addr(32) + wdata(32) + cmd type(6)
    localparam int unsigned EXMEM_DATA_W = 108;

    // Entries held for a given stage state.
    function automatic logic [1:0] occ_of(input pipe_state_t s);
        case (s)
            ONE:     return OCC_ONE;
            TWO:     return OCC_TWO;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for pipeline performance statistics.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         inc_in,
    output logic [W-1:0] cnt_out
);

    // Count enabled events, sticking at all-ones.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_out <= '0;
        end else if (inc_in && (cnt_out != {W{1'b1}})) begin
            cnt_out <= cnt_out + W'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic valid/ready pipeline stage with optional two-entry skid buffer,
// flush-to-bubble, global freeze and back-pressure counter.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = EXMEM_DATA_W,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              up_valid_in,
    input  logic [DATA_W-1:0] up_data_in,
    output logic              up_ready_out,
    output logic              dn_valid_out,
    output logic [DATA_W-1:0] dn_data_out,
    input  logic              dn_ready_in,
    output logic [1:0]        occ_out,
    output logic [CNT_W-1:0]  stall_cnt_out
);

    localparam bit HAS_SKID = (SKID != 0);

    pipe_state_t       state_q, state_nxt;
    logic [DATA_W-1:0] main_q, main_nxt;
    logic [DATA_W-1:0] skid_q, skid_nxt;
    logic              valid_q;
    logic              ready_q;
    logic [1:0]        occ_q;
    logic              acc_up;
    logic              acc_dn;
    logic              stall_inc;

    // With a skid entry the upstream ready is a flop; without it, ready looks through to downstream.
    assign up_ready_out = HAS_SKID ? ready_q : (!valid_q || dn_ready_in);

    assign acc_up    = up_valid_in && up_ready_out && rdy_in;
    assign acc_dn    = valid_q && dn_ready_in && rdy_in;
    assign stall_inc = rdy_in && valid_q && !dn_ready_in;

    assign dn_valid_out = valid_q;
    assign dn_data_out  = main_q;
    assign occ_out      = occ_q;

    // State, payload and derived status registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            occ_q   <= OCC_EMPTY;
        end else begin
            state_q <= state_nxt;
            main_q  <= main_nxt;
            skid_q  <= skid_nxt;
            valid_q <= (state_nxt != EMPTY);
            ready_q <= (state_nxt != TWO);
            occ_q   <= occ_of(state_nxt);
        end
    end

    // Next state and payload moves; empty slots are always written back to zero.
    always_comb begin
        state_nxt = state_q;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush_in) begin
            state_nxt = EMPTY;
            main_nxt  = '0;
            skid_nxt  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc_up) begin
                        state_nxt = ONE;
                        main_nxt  = up_data_in;
                    end
                end
                ONE: begin
                    if (acc_up && acc_dn) begin
                        main_nxt = up_data_in;
                    end else if (acc_up && HAS_SKID) begin
                        state_nxt = TWO;
                        skid_nxt  = up_data_in;
                    end else if (acc_dn) begin
                        state_nxt = EMPTY;
                        main_nxt  = '0;
                    end
                end
                TWO: begin
                    if (acc_dn) begin
                        state_nxt = ONE;
                        main_nxt  = skid_q;
                        skid_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = '0;
                    skid_nxt  = '0;
                end
            endcase
        end
    end

    // Back-pressure statistics; survives flush.
    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .inc_in  (stall_inc),
        .cnt_out (stall_cnt_out)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a SKID=1 and a SKID=0 instance share stimulus,
// each checked every cycle against a queue-level model of the stage.
module tb_pipe_skid_stage;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rdy;
    logic          flush;
    logic          up_valid;
    logic [DW-1:0] up_data;
    logic          dn_ready;

    logic          up_ready_a, dn_valid_a, up_ready_b, dn_valid_b;
    logic [DW-1:0] dn_data_a, dn_data_b;
    logic [1:0]    occ_a, occ_b;
    logic [CW-1:0] stall_a, stall_b;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model: per instance a FIFO of up to 2 (SKID=1) or 1 (SKID=0) words.
    logic [DW-1:0] mq [2][2];
    int            mn [2];
    int            mcnt [2];

    logic [DW-1:0] log_a [$];
    logic [DW-1:0] exp_log [$];
    bit            acc_a;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(DW), .SKID(1), .CNT_W(CW)) u_a (
        .clk_in (clk), .rst_in (rst_n), .rdy_in (rdy), .flush_in (flush),
        .up_valid_in (up_valid), .up_data_in (up_data), .up_ready_out (up_ready_a),
        .dn_valid_out (dn_valid_a), .dn_data_out (dn_data_a), .dn_ready_in (dn_ready),
        .occ_out (occ_a), .stall_cnt_out (stall_a)
    );

    pipe_skid_stage #(.DATA_W(DW), .SKID(0), .CNT_W(CW)) u_b (
        .clk_in (clk), .rst_in (rst_n), .rdy_in (rdy), .flush_in (flush),
        .up_valid_in (up_valid), .up_data_in (up_data), .up_ready_out (up_ready_b),
        .dn_valid_out (dn_valid_b), .dn_data_out (dn_data_b), .dn_ready_in (dn_ready),
        .occ_out (occ_b), .stall_cnt_out (stall_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready(input int i);
        if (i == 0) return mn[0] < 2;
        return (mn[1] == 0) || dn_ready;
    endfunction

    function automatic logic [DW-1:0] m_head(input int i);
        return (mn[i] > 0) ? mq[i][0] : '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mn[i]   = 0;
            mcnt[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        bit up_rdy = m_ready(i);
        bit pop;
        bit push;
        if (rdy && mn[i] > 0 && !dn_ready && mcnt[i] < CMAX) mcnt[i]++;
        if (flush) begin
            mn[i] = 0;
        end else if (rdy) begin
            pop  = (mn[i] > 0) && dn_ready;
            push = up_valid && up_rdy;
            if (pop) begin
                mq[i][0] = mq[i][1];
                mn[i]--;
            end
            if (push) begin
                mq[i][mn[i]] = up_data;
                mn[i]++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".a.valid"}, 32'(dn_valid_a), 32'(mn[0] > 0));
        chk({tag, ".a.data"},  32'(dn_data_a),  32'(m_head(0)));
        chk({tag, ".a.occ"},   32'(occ_a),      32'(mn[0]));
        chk({tag, ".a.ready"}, 32'(up_ready_a), 32'(m_ready(0)));
        chk({tag, ".a.stall"}, 32'(stall_a),    32'(mcnt[0]));
        chk({tag, ".b.valid"}, 32'(dn_valid_b), 32'(mn[1] > 0));
        chk({tag, ".b.data"},  32'(dn_data_b),  32'(m_head(1)));
        chk({tag, ".b.occ"},   32'(occ_b),      32'(mn[1]));
        chk({tag, ".b.ready"}, 32'(up_ready_b), 32'(m_ready(1)));
        chk({tag, ".b.stall"}, 32'(stall_b),    32'(mcnt[1]));
    endtask

    // One clock: check at the falling edge, log drains, advance the model, step past the rising edge.
    task automatic cycle(input string tag);
        @(negedge clk);
        check_outputs(tag);
        if (rdy && dn_valid_a && dn_ready) log_a.push_back(dn_data_a);
        acc_a = up_valid && up_ready_a && rdy && !flush;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string tag);
        chk({tag, ".len"}, 32'(log_a.size()), 32'(exp_log.size()));
        for (int k = 0; k < exp_log.size() && k < log_a.size(); k++)
            chk({tag, ".word"}, 32'(log_a[k]), 32'(exp_log[k]));
    endtask

    initial begin
        bit got_c;
        bit found_d;
        rst_n = 1'b0; rdy = 1'b0; flush = 1'b0;
        up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming, one word per cycle
        rdy = 1'b1;
        dn_ready = 1'b1;
        log_a.delete();
        for (int k = 1; k <= 5; k++) begin
            up_valid = 1'b1;
            up_data  = DW'(k);
            cycle("stream");
        end
        up_valid = 1'b0;
        up_data  = '0;
        cycle("stream.tail");
        cycle("stream.tail");
        exp_log = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5};
        chk_log("stream.order");

        // Back-pressure fills the skid entry
        log_a.delete();
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data = 16'hA; cycle("bp");
        up_data = 16'hB; cycle("bp");
        up_data = 16'hC;
        for (int k = 0; k < 3; k++) cycle("bp.hold");
        chk("bp.occ_two", 32'(occ_a), 32'd2);
        chk("bp.ready_low", 32'(up_ready_a), 32'd0);
        chk("bp.stall_cnt", 32'(stall_a), 32'd4);
        dn_ready = 1'b1;
        got_c = 1'b0;
        for (int k = 0; k < 8 && !got_c; k++) begin
            cycle("bp.release");
            got_c = acc_a;
        end
        chk("bp.accept_c", 32'(got_c), 32'd1);
        up_valid = 1'b0;
        for (int k = 0; k < 4; k++) cycle("bp.drain");
        exp_log = '{16'hA, 16'hB, 16'hC};
        chk_log("bp.order");

        // Flush in TWO with a same-cycle offer
        log_a.delete();
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data = 16'h11; cycle("fl.fill");
        up_data = 16'h12; cycle("fl.fill");
        chk("fl.occ_two", 32'(occ_a), 32'd2);
        flush = 1'b1;
        up_data = 16'hD;
        cycle("fl.flush");
        flush = 1'b0;
        up_valid = 1'b0;
        chk("fl.valid", 32'(dn_valid_a), 32'd0);
        chk("fl.data", 32'(dn_data_a), 32'd0);
        chk("fl.occ", 32'(occ_a), 32'd0);
        dn_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle("fl.idle");
        found_d = 1'b0;
        foreach (log_a[k]) if (log_a[k] == 16'hD) found_d = 1'b1;
        chk("fl.no_d", 32'(found_d), 32'd0);

        // Global freeze
        log_a.delete();
        up_valid = 1'b1;
        up_data = 16'h21; cycle("frz.load");
        up_data = 16'h22;
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) cycle("frz.hold");
        rdy = 1'b1;
        cycle("frz.resume");
        up_data = 16'h23; cycle("frz.resume");
        up_valid = 1'b0;
        for (int k = 0; k < 3; k++) cycle("frz.drain");
        exp_log = '{16'h21, 16'h22, 16'h23};
        chk_log("frz.order");

        // SKID=0 ready follows downstream within the cycle
        up_valid = 1'b1;
        up_data = 16'h31;
        cycle("s0.load");
        up_valid = 1'b0;
        dn_ready = 1'b0;
        #1;
        chk("s0.ready_low", 32'(up_ready_b), 32'd0);
        cycle("s0.stall");
        dn_ready = 1'b1;
        #1;
        chk("s0.ready_high", 32'(up_ready_b), 32'd1);
        cycle("s0.go");
        cycle("s0.go");

        // Counter saturation
        dn_ready = 1'b0;
        up_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            up_data = DW'($urandom);
            cycle("sat");
        end
        chk("sat.a", 32'(stall_a), 32'hF);
        chk("sat.b", 32'(stall_b), 32'hF);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            rdy      = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            up_valid = $urandom_range(0, 1) != 0;
            up_data  = DW'($urandom);
            dn_ready = $urandom_range(0, 3) != 0;
            cycle("rand");
        end

        // Asynchronous reset mid-stream
        rdy = 1'b1; flush = 1'b0; dn_ready = 1'b0;
        up_valid = 1'b1; up_data = 16'h55;
        cycle("rst.fill");
        cycle("rst.fill");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.a.valid", 32'(dn_valid_a), 32'd0);
        chk("rst.a.data", 32'(dn_data_a), 32'd0);
        chk("rst.a.occ", 32'(occ_a), 32'd0);
        chk("rst.a.stall", 32'(stall_a), 32'd0);
        chk("rst.a.ready", 32'(up_ready_a), 32'd1);
        chk("rst.b.valid", 32'(dn_valid_b), 32'd0);
        chk("rst.b.data", 32'(dn_data_b), 32'd0);
        model_reset();
        up_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
